// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the fetch/data memory arbiter
package mem_arbiter_pkg;

    // Transfer sequencing: arbitrate, present request, await response, pulse ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Which requester owns the transfer currently in flight.
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and shared memory port signal bundle
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Instruction fetch port
    logic              imem_valid;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_err;

    // Data access port
    logic              dmem_valid;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [STRB_W-1:0] dmem_wstrb;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_err;

    // Shared downstream memory port
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [STRB_W-1:0] mem_req_wstrb;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;
    logic              mem_resp_err;

    // Arbiter side
    modport slave (
        input  imem_valid, imem_addr,
        input  dmem_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        output imem_ready, imem_rdata, imem_err,
        output dmem_ready, dmem_rdata, dmem_err,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb
    );

    // Pipeline and memory side
    modport master (
        output imem_valid, imem_addr,
        output dmem_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        input  imem_ready, imem_rdata, imem_err,
        input  dmem_ready, dmem_rdata, dmem_err,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding memory port shared by fetch and data
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 256,
    parameter int CNT_W       = 9
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    import mem_arbiter_pkg::*;

    localparam int STRB_W   = DATA_W / 8;
    localparam int STREAK_W = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);
    localparam bit                  TO_EN      = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0]    TO_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              state;
    owner_t              owner;
    logic [STREAK_W-1:0] data_streak;
    logic [CNT_W-1:0]    tcnt;

    logic                req_valid_q;
    logic                req_we_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic [STRB_W-1:0]   req_wstrb_q;

    logic                imem_ready_q;
    logic [DATA_W-1:0]   imem_rdata_q;
    logic                imem_err_q;
    logic                dmem_ready_q;
    logic [DATA_W-1:0]   dmem_rdata_q;
    logic                dmem_err_q;

    logic                grant_mem;
    logic                grant_if;
    logic                timeout_hit;
    logic                fin;
    logic [DATA_W-1:0]   fin_rdata;
    logic                fin_err;

    // Data wins unless fetch has waited out a full streak of data grants.
    assign grant_mem   = bus.dmem_valid && !(bus.imem_valid && (data_streak == STREAK_MAX));
    assign grant_if    = !grant_mem && bus.imem_valid;
    assign timeout_hit = TO_EN && (tcnt == TO_LAST);

    // Decide whether the transfer in flight completes this cycle and with what result;
    // a handshake in the same cycle as the timeout takes precedence.
    always_comb begin
        fin       = 1'b0;
        fin_rdata = '0;
        fin_err   = 1'b0;
        case (state)
            REQ: begin
                if (!bus.mem_req_ready && timeout_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            RESP: begin
                if (bus.mem_resp_valid) begin
                    fin       = 1'b1;
                    fin_rdata = bus.mem_resp_rdata;
                    fin_err   = bus.mem_resp_err;
                end else if (timeout_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: begin
                fin = 1'b0;
            end
        endcase
    end

    // Transfer FSM with registered request, completion and streak/timeout state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= OWN_IF;
            data_streak  <= '0;
            tcnt         <= '0;
            req_valid_q  <= 1'b0;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
            imem_ready_q <= 1'b0;
            imem_rdata_q <= '0;
            imem_err_q   <= 1'b0;
            dmem_ready_q <= 1'b0;
            dmem_rdata_q <= '0;
            dmem_err_q   <= 1'b0;
        end else begin
            imem_ready_q <= 1'b0;
            dmem_ready_q <= 1'b0;
            if (fin) begin
                state       <= DONE;
                req_valid_q <= 1'b0;
                if (owner == OWN_MEM) begin
                    dmem_ready_q <= 1'b1;
                    dmem_rdata_q <= fin_rdata;
                    dmem_err_q   <= fin_err;
                end else begin
                    imem_ready_q <= 1'b1;
                    imem_rdata_q <= fin_rdata;
                    imem_err_q   <= fin_err;
                end
            end else begin
                case (state)
                    IDLE: begin
                        tcnt <= '0;
                        if (grant_mem) begin
                            owner       <= OWN_MEM;
                            if (data_streak != STREAK_MAX) begin
                                data_streak <= data_streak + STREAK_W'(1);
                            end
                            req_valid_q <= 1'b1;
                            req_we_q    <= bus.dmem_we;
                            req_addr_q  <= bus.dmem_addr;
                            req_wdata_q <= bus.dmem_wdata;
                            req_wstrb_q <= bus.dmem_wstrb;
                            state       <= REQ;
                        end else if (grant_if) begin
                            owner       <= OWN_IF;
                            data_streak <= '0;
                            req_valid_q <= 1'b1;
                            req_we_q    <= 1'b0;
                            req_addr_q  <= bus.imem_addr;
                            req_wdata_q <= '0;
                            req_wstrb_q <= '1;
                            state       <= REQ;
                        end
                    end
                    REQ: begin
                        tcnt <= tcnt + CNT_W'(1);
                        if (bus.mem_req_ready) begin
                            req_valid_q <= 1'b0;
                            state       <= RESP;
                        end
                    end
                    RESP: begin
                        tcnt <= tcnt + CNT_W'(1);
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_we    = req_we_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_req_wdata = req_wdata_q;
    assign bus.mem_req_wstrb = req_wstrb_q;
    assign bus.imem_ready    = imem_ready_q;
    assign bus.imem_rdata    = imem_rdata_q;
    assign bus.imem_err      = imem_err_q;
    assign bus.dmem_ready    = dmem_ready_q;
    assign bus.dmem_rdata    = dmem_rdata_q;
    assign bus.dmem_err      = dmem_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for the fetch/data memory arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(4), .TIMEOUT(8), .CNT_W(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    req_t iq[$];
    req_t dq[$];
    req_t exp_req[$];
    rsp_t exp_i[$];
    rsp_t exp_d[$];
    logic [31:0] mem [logic [31:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic req_t mk(logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] ws);
        req_t r;
        r.we = we; r.addr = a; r.wdata = wd; r.wstrb = ws;
        return r;
    endfunction

    function automatic logic [31:0] mem_read(logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    function automatic void mem_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
        logic [31:0] w;
        w = mem_read(a);
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mem[a] = w;
    endfunction

    task automatic fetch(input logic [31:0] a, input logic [31:0] rd, input logic er, input int lat);
        rsp_t e;
        e.rdata = rd; e.err = er; e.lat = lat;
        iq.push_back(mk(1'b0, a, 32'h0, 4'hF));
        exp_i.push_back(e);
    endtask

    task automatic data(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] rd, input logic er, input int lat);
        rsp_t e;
        e.rdata = rd; e.err = er; e.lat = lat;
        dq.push_back(mk(we, a, wd, ws));
        exp_d.push_back(e);
    endtask

    // Requesters: hold valid until ready, score each completion, then load the next request.
    logic i_busy = 1'b0, d_busy = 1'b0, i_hold = 1'b0, i_release = 1'b0;
    int   i_start = 0, d_start = 0, i_done = 0, d_done = 0, i_rdy_cyc = 0, d_rdy_cyc = 0;
    req_t i_cur, d_cur;
    rsp_t ei, ed;

    always @(negedge clk) begin
        if (rst) begin
            i_busy = 1'b0; d_busy = 1'b0; i_release = 1'b0;
            bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0;
        end else begin
            check("ready_exclusive", 64'(bus.imem_ready & bus.dmem_ready), 64'(0));
            if (i_release) begin
                i_release = 1'b0; i_busy = 1'b0;
            end
            if (bus.imem_ready) begin
                check("imem_ready_when_busy", 64'(i_busy), 64'(1));
                check("imem_rsp_expected", 64'(exp_i.size() > 0), 64'(1));
                i_done++; i_rdy_cyc = cyc;
                if (exp_i.size() > 0) begin
                    ei = exp_i.pop_front();
                    check("imem_rdata", bus.imem_rdata, ei.rdata);
                    check("imem_err", bus.imem_err, ei.err);
                    if (ei.lat >= 0) check("imem_latency", 64'(cyc - i_start), 64'(ei.lat));
                end
                if (i_hold) i_release = 1'b1;
                else i_busy = 1'b0;
            end
            if (bus.dmem_ready) begin
                check("dmem_ready_when_busy", 64'(d_busy), 64'(1));
                check("dmem_rsp_expected", 64'(exp_d.size() > 0), 64'(1));
                d_done++; d_rdy_cyc = cyc; d_busy = 1'b0;
                if (exp_d.size() > 0) begin
                    ed = exp_d.pop_front();
                    check("dmem_rdata", bus.dmem_rdata, ed.rdata);
                    check("dmem_err", bus.dmem_err, ed.err);
                    if (ed.lat >= 0) check("dmem_latency", 64'(cyc - d_start), 64'(ed.lat));
                end
            end
            if (!i_busy) begin
                if (iq.size() > 0) begin
                    i_cur = iq.pop_front();
                    bus.imem_valid = 1'b1; bus.imem_addr = i_cur.addr;
                    i_busy = 1'b1; i_start = cyc;
                end else begin
                    bus.imem_valid = 1'b0;
                end
            end
            if (!d_busy) begin
                if (dq.size() > 0) begin
                    d_cur = dq.pop_front();
                    bus.dmem_valid = 1'b1; bus.dmem_we = d_cur.we; bus.dmem_addr = d_cur.addr;
                    bus.dmem_wdata = d_cur.wdata; bus.dmem_wstrb = d_cur.wstrb;
                    d_busy = 1'b1; d_start = cyc;
                end else begin
                    bus.dmem_valid = 1'b0;
                end
            end
        end
    end

    // Downstream memory: optional stall before accepting, response one cycle after acceptance.
    logic active = 1'b0, hs_pending = 1'b0, hs_we = 1'b0, resp_en = 1'b1, inject = 1'b0;
    logic [31:0] hs_addr = 32'h0;
    int   stall_left = 0, stall_knob = 0, req_cnt = 0;
    req_t er;

    always @(negedge clk) begin
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_err   = 1'b0;
        bus.mem_req_ready  = 1'b0;
        if (rst) begin
            active = 1'b0; hs_pending = 1'b0;
        end else begin
            if (hs_pending) begin
                hs_pending = 1'b0;
                if (resp_en) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_rdata = hs_we ? 32'h0 : mem_read(hs_addr);
                end
            end else if (inject) begin
                inject = 1'b0;
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_rdata = 32'hDEADBEEF;
            end
            if (bus.mem_req_valid) begin
                if (!active) begin
                    active = 1'b1; stall_left = stall_knob;
                end
                check("req_expected", 64'(exp_req.size() > 0), 64'(1));
                if (exp_req.size() > 0) begin
                    er = exp_req[0];
                    check("req_we", bus.mem_req_we, er.we);
                    check("req_addr", bus.mem_req_addr, er.addr);
                    check("req_wstrb", bus.mem_req_wstrb, er.wstrb);
                    if (er.we) check("req_wdata", bus.mem_req_wdata, er.wdata);
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    bus.mem_req_ready = 1'b1;
                    hs_pending = 1'b1; active = 1'b0; req_cnt++;
                    hs_we = bus.mem_req_we; hs_addr = bus.mem_req_addr;
                    if (bus.mem_req_we) mem_write(bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wstrb);
                    if (exp_req.size() > 0) er = exp_req.pop_front();
                end
            end
        end
    end

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_i.size() != 0 || exp_d.size() != 0) && n < budget) begin
            @(negedge clk); n++;
        end
        check(tag, 64'(exp_i.size() + exp_d.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_ctl"}, 64'({bus.imem_ready, bus.imem_err, bus.dmem_ready, bus.dmem_err,
                                  bus.mem_req_valid, bus.mem_req_we}), 64'(0));
        check({pfx, "_rdata"}, {bus.imem_rdata, bus.dmem_rdata}, 64'(0));
        check({pfx, "_req_addr"}, bus.mem_req_addr, 64'(0));
        check({pfx, "_req_wdata"}, bus.mem_req_wdata, 64'(0));
        check({pfx, "_req_wstrb"}, bus.mem_req_wstrb, 64'(0));
        check({pfx, "_state"}, 64'(dut.state), 64'(IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_i;
        int base_d;
        int base_r;
        int n;
        bus.imem_valid = 1'b0; bus.imem_addr = '0;
        bus.dmem_valid = 1'b0; bus.dmem_we = 1'b0; bus.dmem_addr = '0;
        bus.dmem_wdata = '0; bus.dmem_wstrb = '0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0; bus.mem_resp_err = 1'b0;
        mem[32'h100] = 32'h00000013;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Fetch only, valid held through DONE
        i_hold = 1'b1;
        base_r = req_cnt;
        fetch(32'h100, 32'h13, 1'b0, 3);
        exp_req.push_back(mk(1'b0, 32'h100, 32'h0, 4'hF));
        @(negedge clk);
        check("t1_req_valid_n", 64'(bus.mem_req_valid), 64'(0));
        @(negedge clk);
        check("t1_req_valid_n1", 64'(bus.mem_req_valid), 64'(1));
        wait_idle("t1_done", 40);
        repeat (5) @(negedge clk);
        check("t1_no_reissue", 64'(req_cnt - base_r), 64'(1));
        i_hold = 1'b0;
        @(posedge clk); #1;

        // Simultaneous store and fetch: data first
        data(1'b1, 32'h2000, 32'hCAFEBABE, 4'hF, 32'h0, 1'b0, 3);
        fetch(32'h104, ~32'h104, 1'b0, 7);
        exp_req.push_back(mk(1'b1, 32'h2000, 32'hCAFEBABE, 4'hF));
        exp_req.push_back(mk(1'b0, 32'h104, 32'h0, 4'hF));
        wait_idle("t2_done", 60);
        check("t2_dmem_before_imem", 64'(d_rdy_cyc < i_rdy_cyc), 64'(1));

        // Starvation bound: four data, one fetch, data resumes
        data(1'b0, 32'h2000, 32'h0, 4'h0, 32'hCAFEBABE, 1'b0, 3);
        for (int k = 0; k < 5; k++)
            data(1'b0, 32'h3000 + 32'(4 * k), 32'h0, 4'h0, ~(32'h3000 + 32'(4 * k)), 1'b0, -1);
        fetch(32'h108, ~32'h108, 1'b0, 19);
        exp_req.push_back(mk(1'b0, 32'h2000, 32'h0, 4'h0));
        for (int k = 0; k < 3; k++) exp_req.push_back(mk(1'b0, 32'h3000 + 32'(4 * k), 32'h0, 4'h0));
        exp_req.push_back(mk(1'b0, 32'h108, 32'h0, 4'hF));
        for (int k = 3; k < 5; k++) exp_req.push_back(mk(1'b0, 32'h3000 + 32'(4 * k), 32'h0, 4'h0));
        wait_idle("t3_done", 120);

        // Backpressure: five stall cycles add exactly five cycles
        stall_knob = 5;
        fetch(32'h10C, ~32'h10C, 1'b0, 8);
        exp_req.push_back(mk(1'b0, 32'h10C, 32'h0, 4'hF));
        wait_idle("t4_done", 60);
        stall_knob = 0;

        // Timeout: no response, error completion, late response ignored
        resp_en = 1'b0;
        data(1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, 9);
        exp_req.push_back(mk(1'b0, 32'h400, 32'h0, 4'h0));
        wait_idle("t5_done", 60);
        base_i = i_done; base_d = d_done;
        inject = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_late_resp_ignored", 64'((i_done - base_i) + (d_done - base_d)), 64'(0));
        resp_en = 1'b1;
        @(posedge clk); #1;

        // Reset while awaiting a response
        resp_en = 1'b0;
        base_r = req_cnt;
        iq.push_back(mk(1'b0, 32'h500, 32'h0, 4'hF));
        exp_req.push_back(mk(1'b0, 32'h500, 32'h0, 4'hF));
        n = 0;
        while (req_cnt == base_r && n < 20) begin
            @(negedge clk); n++;
        end
        check("t6_req_accepted", 64'(req_cnt - base_r), 64'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("t6_reset");
        rst = 1'b0;
        resp_en = 1'b1;
        fetch(32'h100, 32'h13, 1'b0, 3);
        exp_req.push_back(mk(1'b0, 32'h100, 32'h0, 4'hF));
        wait_idle("t6_after_reset", 40);

        repeat (3) @(negedge clk);
        check("end_req_queue_empty", 64'(exp_req.size()), 64'(0));
        check("end_driver_queues_empty", 64'(iq.size() + dq.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
